wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Write-back trace buffer that sits beside the `mips` core in simulation and FPGA builds. It captures each architectural write event the core commits, either a GRF write or a DM store, together with its PC, address and data. It buffers the events in order and presents them on a valid/ready stream to a trace consumer such as a UART dumper or a bench checker. It also tracks overflow, so that lost events can be detected instead of silently corrupting a trace comparison.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `PTR_W`, $clog2(DEPTH): pointer width (derived).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `ev_valid`  in  1  core commits a write this cycle.
- `ev_kind`  in  1  0 = GRF write, 1 = DM store.
- `ev_pc`  in  32  PC of committing instruction.
- `ev_addr`  in  32  GRF: register number in [4:0], upper bits ignored and stored as 0; DM: byte address.
- `ev_data`  in  32  written value.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_kind`, `out_pc`, `out_addr`, `out_data`  out  1/32/32/32  head entry fields.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `overflow`  out  1  sticky; set on the first dropped event.
- `drop_cnt`  out  16  dropped events, saturating at 16'hFFFF.

## Operation
- **Push:** accepted when `ev_valid` is high and the event passes the filter (see Configuration), and either `count < DEPTH` or a pop occurs in the same cycle.
- **Pop:** occurs when `out_valid && out_ready`.
- **Storage:** circular buffer with write pointer `wp` and read pointer `rp`, each PTR_W bits and wrapping modulo DEPTH. `count` is a separate register.
  - Push only: count+1.
  - Pop only: count−1.
  - Both: count unchanged.
- **Show-ahead output:** `out_*` reflect `mem[rp]` combinationally. `out_valid = (count != 0)`. Output fields are don't-care while `out_valid` = 0.
- **Ordering:** strictly FIFO. No reordering, merging or coalescing.
- **Full with no pop:** a valid, filter-passing event is dropped.
  - `overflow` ← 1.
  - `drop_cnt` += 1, saturating.
  - Stored contents are untouched.
- **Full with a simultaneous pop:** the push is accepted and nothing is dropped.
- **Empty with `ev_valid` and `out_ready`:** the push is accepted. The pop does not occur, because `out_valid` was 0.
- **Clearing:** `overflow` and `drop_cnt` clear only on `reset`.

## Timing
- **Reset values** (registered on the first edge with `reset` = 1):
  - `wp` = `rp` = `count` = 0.
  - `out_valid` = 0, `full` = 0, `overflow` = 0, `drop_cnt` = 0.
  - `out_kind`/`out_pc`/`out_addr`/`out_data` = 0; storage array cleared.
- **Reset priority:** `reset` overrides push and pop in the same cycle. A reset mid-stream discards all buffered entries.
- **Latency:** an event pushed at edge N makes `out_valid` = 1 with its fields in the cycle after edge N (1-cycle latency).
- **Throughput:** 1 push and 1 pop per cycle sustained.
- **Status update:** `count`, `full`, `overflow` and `drop_cnt` update on the same edge as the push or pop that changes them.
- **Stream rule:** once `out_valid` is high, the head fields stay stable until popped. Entries are never withdrawn except by `reset`.

## Configuration
- Macro: `WB_TRACE_ZERO_FILTER_EN`.
- **Defined:** GRF events (`ev_kind` = 0) with `ev_addr[4:0]` == 0 are discarded before the push decision.
  - They never occupy a slot.
  - They never count as drops.
  - This matches the golden trace, which omits $0 writes.
- **Undefined:** every `ev_valid` event is a push candidate, including $0 writes.

## Test plan
- **Reset, then single push.** Reset 2 cycles, then push {kind 0, pc 0x3000, addr 5, data 0x12345678}, `out_ready` = 0. Required: next cycle `out_valid` = 1 with exactly those fields and `count` = 1. Then `out_ready` = 1 for 1 cycle → `count` = 0, `out_valid` = 0.
- **Fill, overflow, drain.** DEPTH = 16, `out_ready` = 0, push 18 events with data 0..17. Required: `full` = 1 after 16 pushes, `overflow` = 1, `drop_cnt` = 2. Draining returns data 0..15 in order.
- **Push and pop on a full buffer.** Buffer full; `ev_valid` = 1 (data 0xAA) and `out_ready` = 1 in the same cycle. Required: `count` stays 16, `drop_cnt` unchanged, 0xAA becomes the last entry.
- **Wrap-around with a stalling consumer.** Interleave 40 pushes with a randomly stalling `out_ready`, occupancy kept < 16. Required: output sequence equals input sequence, `overflow` = 0.
- **$0 write filter.** Push {kind 0, addr 0, data 7}. Required: with `WB_TRACE_ZERO_FILTER_EN` defined, `count` stays 0. Without it, `count` = 1 and `out_data` = 7. In both builds, a DM event with addr 0 is stored.
- **Reset mid-stream.** 5 entries buffered, `overflow` = 1; assert `reset` together with push and pop. Required: next cycle `count` = 0, `out_valid` = 0, `overflow` = 0, `drop_cnt` = 0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: in-order buffer of committed architectural write events
// (GRF writes and DM stores) presented on a show-ahead valid/ready stream,
// with sticky overflow and a saturating count of dropped events.
// Optional feature macro: WB_TRACE_ZERO_FILTER_EN -- when defined, GRF
// writes to register $0 are discarded before they can occupy a slot.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_valid,
    input  logic             ev_kind,
    input  logic [31:0]      ev_pc,
    input  logic [31:0]      ev_addr,
    input  logic [31:0]      ev_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Saturating increment for the drop counter; it sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    logic             mem_kind [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;

    logic        cand;
    logic        pop;
    logic        push;
    logic        drop;
    logic [31:0] addr_norm;

`ifdef WB_TRACE_ZERO_FILTER_EN
    // $0 writes never reach the golden trace, so they are not candidates.
    assign cand = ev_valid && !((ev_kind == 1'b0) && (ev_addr[4:0] == 5'd0));
`else
    assign cand = ev_valid;
`endif

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push needs when full.
    assign push      = cand && (!full || pop);
    assign drop      = cand && full && !pop;

    // GRF events only carry a register number; upper address bits read as 0.
    assign addr_norm = ev_kind ? ev_addr : {27'd0, ev_addr[4:0]};

    // Show-ahead head entry.
    assign out_kind  = mem_kind[rp];
    assign out_pc    = mem_pc[rp];
    assign out_addr  = mem_addr[rp];
    assign out_data  = mem_data[rp];

    // Entry storage: written at wp on an accepted push, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_kind[i] <= 1'b0;
                mem_pc[i]   <= '0;
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else if (push) begin
            mem_kind[wp] <= ev_kind;
            mem_pc[wp]   <= ev_pc;
            mem_addr[wp] <= addr_norm;
            mem_data[wp] <= ev_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Loss tracking: sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc16(drop_cnt);
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo (DEPTH = 16).
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        ev_valid;
    logic        ev_kind;
    logic [31:0] ev_pc;
    logic [31:0] ev_addr;
    logic [31:0] ev_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic [15:0] drop_cnt;

    int tests  = 0;
    int failed = 0;

    wb_trace_fifo #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_pc(ev_pc),
        .ev_addr(ev_addr), .ev_data(ev_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; ev_valid = 1'b0; out_ready = 1'b0;
        ev_kind = 1'b0; ev_pc = '0; ev_addr = '0; ev_data = '0;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    task automatic push_ev(input logic k, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] d);
        ev_valid = 1'b1; ev_kind = k; ev_pc = pc; ev_addr = a; ev_data = d;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        tests++; if (count !== 5'd0)      begin failed++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (out_valid !== 1'b0)  begin failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if (full !== 1'b0)       begin failed++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (overflow !== 1'b0)   begin failed++; $display("FAIL reset_ovf got %b want 0", overflow); end
        tests++; if (drop_cnt !== 16'd0)  begin failed++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        tests++; if (out_data !== 32'd0 || out_pc !== 32'd0)
            begin failed++; $display("FAIL reset_head got pc=%h data=%h want 0/0", out_pc, out_data); end
    endtask

    task automatic test_single_push();
        do_reset(2);
        push_ev(1'b0, 32'h3000, 32'd5, 32'h1234_5678);
        tests++; if (out_valid !== 1'b1)  begin failed++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests++; if (count !== 5'd1)      begin failed++; $display("FAIL single_count got %0d want 1", count); end
        tests++; if (out_kind !== 1'b0 || out_pc !== 32'h3000 || out_addr !== 32'd5 || out_data !== 32'h1234_5678)
            begin failed++; $display("FAIL single_fields got k=%b pc=%h a=%h d=%h want 0/3000/5/12345678",
                                     out_kind, out_pc, out_addr, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++; if (count !== 5'd0 || out_valid !== 1'b0)
            begin failed++; $display("FAIL single_pop got count=%0d valid=%b want 0/0", count, out_valid); end
        // GRF upper address bits are stored as zero; DM addresses are kept.
        push_ev(1'b0, 32'h3004, 32'hFFFF_FFE5, 32'd1);
        push_ev(1'b1, 32'h3008, 32'hFFFF_FFE5, 32'd2);
        tests++; if (out_addr !== 32'h0000_0005)
            begin failed++; $display("FAIL grf_addr_mask got %h want 00000005", out_addr); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        tests++; if (out_kind !== 1'b1 || out_addr !== 32'hFFFF_FFE5)
            begin failed++; $display("FAIL dm_addr got k=%b a=%h want 1/ffffffe5", out_kind, out_addr); end
    endtask

    task automatic test_fill_overflow_drain();
        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            push_ev(1'b1, 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 32'(i));
            if (i == 15) begin
                tests++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0)
                    begin failed++; $display("FAIL fill16 got full=%b count=%0d ovf=%b want 1/16/0", full, count, overflow); end
            end
        end
        tests++; if (overflow !== 1'b1 || drop_cnt !== 16'd2 || count !== 5'd16)
            begin failed++; $display("FAIL overflow got ovf=%b drop=%0d count=%0d want 1/2/16", overflow, drop_cnt, count); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests++; if (out_valid !== 1'b1 || out_data !== 32'(i))
                begin failed++; $display("FAIL drain_%0d got valid=%b data=%0d want 1/%0d", i, out_valid, out_data, i); end
            step();
        end
        out_ready = 1'b0;
        tests++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 16'd2)
            begin failed++; $display("FAIL drained got count=%0d valid=%b ovf=%b drop=%0d want 0/0/1/2",
                                     count, out_valid, overflow, drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        do_reset(1);
        for (int i = 0; i < 16; i++) push_ev(1'b1, 32'h5000, 32'h200, 32'd100 + 32'(i));
        out_ready = 1'b1;
        push_ev(1'b1, 32'h5040, 32'h200, 32'hAA);
        out_ready = 1'b0;
        tests++; if (count !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0)
            begin failed++; $display("FAIL fullpp got count=%0d drop=%0d ovf=%b want 16/0/0", count, drop_cnt, overflow); end
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tests++; if (out_data !== 32'd100 + 32'(i))
                begin failed++; $display("FAIL fullpp_drain_%0d got %0d want %0d", i, out_data, 100 + i); end
            step();
        end
        tests++; if (out_data !== 32'hAA || count !== 5'd1)
            begin failed++; $display("FAIL fullpp_last got data=%h count=%0d want aa/1", out_data, count); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        int pushed;
        int popped;
        int cyc;
        pushed = 0; popped = 0; cyc = 0;
        do_reset(1);
        while ((pushed < 40 || q.size() != 0) && cyc < 2000) begin
            out_ready = ($urandom_range(0, 2) != 0);
            ev_valid  = (pushed < 40) && (q.size() < 14) && ($urandom_range(0, 3) != 0);
            ev_kind = 1'b1; ev_pc = 32'h6000 + 32'(pushed); ev_addr = 32'(pushed);
            ev_data = 32'hC000_0000 + 32'(pushed);
            tests++; if (count !== 5'(q.size()))
                begin failed++; $display("FAIL wrap_count cyc %0d got %0d want %0d", cyc, count, q.size()); end
            if (out_ready && q.size() != 0) begin
                tests++; if (out_data !== q[0])
                    begin failed++; $display("FAIL wrap_data cyc %0d got %h want %h", cyc, out_data, q[0]); end
            end
            step();
            if (out_ready && q.size() != 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (ev_valid) begin
                q.push_back(32'hC000_0000 + 32'(pushed));
                pushed++;
            end
            cyc++;
        end
        ev_valid = 1'b0; out_ready = 1'b0;
        tests++; if (popped != 40)
            begin failed++; $display("FAIL wrap_total got %0d popped want 40 (cycles %0d)", popped, cyc); end
        tests++; if (overflow !== 1'b0)
            begin failed++; $display("FAIL wrap_ovf got %b want 0", overflow); end
    endtask

    task automatic test_zero_filter();
        do_reset(1);
        push_ev(1'b0, 32'h7000, 32'd0, 32'd7);
`ifdef WB_TRACE_ZERO_FILTER_EN
        tests++; if (count !== 5'd0 || out_valid !== 1'b0)
            begin failed++; $display("FAIL zero_filt got count=%0d valid=%b want 0/0", count, out_valid); end
`else
        tests++; if (count !== 5'd1 || out_data !== 32'd7)
            begin failed++; $display("FAIL zero_nofilt got count=%0d data=%0d want 1/7", count, out_data); end
`endif
        out_ready = 1'b1;
        if (out_valid) step();
        out_ready = 1'b0;
        push_ev(1'b1, 32'h7004, 32'd0, 32'd9);
        tests++; if (count !== 5'd1 || out_kind !== 1'b1 || out_data !== 32'd9)
            begin failed++; $display("FAIL zero_dm got count=%0d k=%b data=%0d want 1/1/9", count, out_kind, out_data); end
        tests++; if (drop_cnt !== 16'd0)
            begin failed++; $display("FAIL zero_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_reset_midstream();
        do_reset(1);
        for (int i = 0; i < 17; i++) push_ev(1'b1, 32'h8000, 32'h300, 32'(i));
        out_ready = 1'b1;
        repeat (11) step();
        out_ready = 1'b0;
        tests++; if (count !== 5'd5 || overflow !== 1'b1 || drop_cnt !== 16'd1)
            begin failed++; $display("FAIL mid_setup got count=%0d ovf=%b drop=%0d want 5/1/1", count, overflow, drop_cnt); end
        reset = 1'b1; out_ready = 1'b1;
        push_ev(1'b1, 32'h8100, 32'h300, 32'h55);
        reset = 1'b0; out_ready = 1'b0;
        tests++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0)
            begin failed++; $display("FAIL mid_reset got count=%0d valid=%b ovf=%b drop=%0d want 0/0/0/0",
                                     count, out_valid, overflow, drop_cnt); end
        tests++; if (out_data !== 32'd0)
            begin failed++; $display("FAIL mid_reset_head got %h want 0", out_data); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow_drain();
        test_full_push_pop();
        test_wrap();
        test_zero_filter();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
